// File: rtl/stroke_link_pkg.sv
// Shared definitions for the stroke link (receiver and transmitter).
// Holds the code width, field widths/offsets within the 26-bit code word
// {x[9:0], y[8:0], color[3:0], sw[2:0]}, and the receiver state encoding.
package stroke_link_pkg;

  localparam int CODE_W    = 26;

  localparam int X_W       = 10;
  localparam int Y_W       = 9;
  localparam int COLOR_W   = 4;
  localparam int SW_W      = 3;

  localparam int SW_LSB    = 0;
  localparam int COLOR_LSB = SW_LSB + SW_W;       // 3
  localparam int Y_LSB     = COLOR_LSB + COLOR_W; // 7
  localparam int X_LSB     = Y_LSB + Y_W;         // 16

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } stroke_state_e;

endpackage

// File: rtl/stroke_code_rx.sv
// Stroke-link serial receiver.
// Frame: start(0), 26 data bits MSB first, even parity, stop(1).
// Ports:
//   clk_in          sole clock, rising edge
//   rst_in          async active-low reset
//   serial_in       line input (idle high), already synchronized
//   busy_out        high while a frame is being received
//   valid_out       1-cycle pulse, new good code on code_out / fields
//   code_out        last good 26-bit code
//   x_out/y_out/color_out/sw_out  slices of code_out
//   parity_err_out  1-cycle pulse, frame dropped on bad parity
//   frame_err_out   1-cycle pulse, frame dropped on bad stop bit
module stroke_code_rx
  import stroke_link_pkg::*;
#(
  parameter int unsigned CYCLES_PER_BIT = 100
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                serial_in,
  output logic                busy_out,
  output logic                valid_out,
  output logic [CODE_W-1:0]   code_out,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOR_W-1:0]  color_out,
  output logic [SW_W-1:0]     sw_out,
  output logic                parity_err_out,
  output logic                frame_err_out
);

  localparam logic [9:0] HALF_CNT = 10'(CYCLES_PER_BIT / 2);
  localparam logic [9:0] LAST_CNT = 10'(CYCLES_PER_BIT - 1);
  localparam logic [4:0] LAST_BIT = 5'(CODE_W - 1);

  stroke_state_e     state_q, state_d;
  logic [9:0]        cnt_q, cnt_d;
  logic [4:0]        bit_q, bit_d;
  logic [CODE_W-1:0] shift_q, shift_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              par_q, par_d;
  // Set after a bad stop bit: stay in STOP until the line returns high so a
  // held-low line is not mistaken for a new start bit.
  logic              brk_q, brk_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 10'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    code_d  = code_q;
    par_d   = par_q;
    brk_d   = brk_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        brk_d = 1'b0;
        if (!serial_in) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (serial_in) begin
            state_d = ST_IDLE;  // false start
          end else begin
            state_d = ST_DATA;
            bit_d   = '0;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          shift_d = {shift_q[CODE_W-2:0], serial_in};
          bit_d   = bit_q + 5'd1;
          if (bit_q == LAST_BIT) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          par_d   = serial_in;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (brk_q) begin
          cnt_d = '0;
          if (serial_in) state_d = ST_IDLE;
        end else if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (!serial_in) begin
            ferr_d = 1'b1;  // stop error wins over parity
            brk_d  = 1'b1;
          end else if ((^shift_q) ^ par_q) begin
            perr_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            valid_d = 1'b1;
            code_d  = shift_q;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      code_q  <= '0;
      par_q   <= 1'b0;
      brk_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      code_q  <= code_d;
      par_q   <= par_d;
      brk_q   <= brk_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign busy_out       = busy_q;
  assign valid_out      = valid_q;
  assign parity_err_out = perr_q;
  assign frame_err_out  = ferr_q;
  assign code_out       = code_q;
  assign x_out          = code_q[X_LSB     +: X_W];
  assign y_out          = code_q[Y_LSB     +: Y_W];
  assign color_out      = code_q[COLOR_LSB +: COLOR_W];
  assign sw_out         = code_q[SW_LSB    +: SW_W];

endmodule
